sar_adc_ctrl: RTL
=================

// Module: sar_adc_ctrl
// PURPOSE
//  Successive-approximation controller that consumes the latch-comparator output (Vip vs Vin).
//  Drives a WIDTH-bit trial code to the external/off-block DAC, samples the comparator once per bit
//  and returns the binary conversion result with a one-cycle valid strobe.
//  Sits directly downstream of the comparator stage inside the same tt_um top; dac_code goes to pads.
// PARAMETERS
//  WIDTH       8   conversion resolution in bits (>=2)
//  SETTLE_CYC  3   cycles allowed per bit for DAC settling + comparator sync; must be >=2 (sync depth)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      request conversion; honoured only in IDLE
//  cmp_in     in   1      raw comparator output, asynchronous; 1 = input above trial code
//  dac_code   out  WIDTH  current trial code to DAC
//  result     out  WIDTH  last completed conversion; held until next completion
//  valid      out  1      one-cycle strobe, result updated
//  busy       out  1      high while in SETTLE/DECIDE
// BEHAVIOUR
//  Clocking: one clock (clk); reset is synchronous and active-low (rst_n); all outputs registered.
//  Reset: state=IDLE, dac_code=0, result=0, valid=0, busy=0, bit index=WIDTH-1, settle cnt=0, sync=0.
//  Reset wins over every other event; asserted mid-conversion aborts it, result cleared to 0.
//  cmp_in passes 2-flop synchronizer; only synchronized value (cmp_s) is used.
//  FSM: IDLE -> SETTLE -> DECIDE -> (SETTLE | DONE) -> IDLE.
//   IDLE:   start=1 at edge k -> SETTLE; idx=WIDTH-1; dac_code={1'b1,{WIDTH-1{0}}}; cnt=0; busy=1.
//   SETTLE: cnt increments each edge; after SETTLE_CYC edges in SETTLE -> DECIDE.
//   DECIDE: one cycle. dac_code[idx] <= cmp_s (keep bit if 1, clear if 0).
//           idx!=0: idx--, set dac_code[idx-1]=1, cnt=0 -> SETTLE.
//           idx==0: result <= final code (incl. bit0 decision), valid=1, busy=0 -> DONE.
//   DONE:   one cycle; valid=1; next edge valid=0 -> IDLE; dac_code holds final code.
//  Latency: valid high in the cycle after edge k+WIDTH*(SETTLE_CYC+1); default 32 cycles.
//  start while busy or in DONE: ignored, not queued. start held high: new conversion accepted
//   in the IDLE cycle after DONE (back-to-back period WIDTH*(SETTLE_CYC+1)+2 edges).
//  Bit idx update writes only bit idx / idx-1; upper decided bits never change within conversion.
//  Result is unsigned binary; no overflow possible; idx never wraps (DONE path at idx==0).
// STRUCTURE
//  Shared package/header semis_pkg: FSM state encodings (IDLE/SETTLE/DECIDE/DONE, 2-bit),
//   SYNC_DEPTH=2 constant, default WIDTH/SETTLE_CYC.
//  One sub-module: cmp_sync (2-flop synchronizer, sync active-low reset to 0).
//  Counter width $clog2(SETTLE_CYC+1); idx width $clog2(WIDTH).
// TESTING
//  T1 cmp_in tied 1, pulse start -> result=0xFF, valid exactly 1 cycle, 32 cycles after start edge.
//  T2 cmp_in tied 0 -> result=0x00; dac_code sequence 0x80,0x40,...,0x01 one per bit.
//  T3 behavioural model cmp_in = (0xA5 >= dac_code) -> trial codes 80,C0,A0,B0,A8,A4,A6,A5; result=0xA5.
//  T4 start re-pulsed at cycles 5 and 31 of a conversion -> ignored; result/latency unchanged;
//     start held high -> second valid exactly 34 edges after first.
//  T5 rst_n low for 1 cycle at cycle 12 of conversion -> next edge all outputs at reset values,
//     no valid; fresh start then converts correctly.
//  T6 SETTLE_CYC=2, WIDTH=4, model value 0x9 -> result=0x9, valid 12 cycles after start.

Source files
------------

// File: rtl/semis_pkg.sv
// Shared constants for the SAR conversion path: FSM encodings, synchronizer depth
// and default converter geometry.
package semis_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SYNC_DEPTH     = 2;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SETTLE_CYC = 3;

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous latch-comparator output.
// Clears to 0 under synchronous active-low reset.
module cmp_sync
    import semis_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], async_in};
        end
    end

    assign sync_out = r_sync[DEPTH-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes to the DAC, decides one bit
// per SETTLE_CYC+1 cycles from the synchronized comparator and strobes the result.
module sar_adc_ctrl
    import semis_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] FIRST_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dac;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_busy;

    logic             w_cmp_s;
    logic [IDX_W-1:0] w_idx_dn;

    cmp_sync #(
        .DEPTH(SYNC_DEPTH)
    ) u_cmp_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(cmp_in),
        .sync_out(w_cmp_s)
    );

    assign w_idx_dn = r_idx - IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= IDX_W'(WIDTH - 1);
            r_cnt    <= '0;
            r_dac    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_idx   <= IDX_W'(WIDTH - 1);
                        r_dac   <= FIRST_TRIAL;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // SETTLE_CYC edges covers DAC settling plus the synchronizer latency
                    if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        r_state <= ST_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    r_dac[r_idx] <= w_cmp_s;
                    if (r_idx != '0) begin
                        r_dac[w_idx_dn] <= 1'b1;
                        r_idx           <= w_idx_dn;
                        r_cnt           <= '0;
                        r_state         <= ST_SETTLE;
                    end else begin
                        r_result <= {r_dac[WIDTH-1:1], w_cmp_s};
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_code = r_dac;
    assign result   = r_result;
    assign valid    = r_valid;
    assign busy     = r_busy;

endmodule
